// File: rtl/plic_lite_pkg.sv
// Shared definitions for plic_lite: gateway state encoding, interrupt bus width
// and the word offsets of the memory-mapped registers.
package plic_lite_pkg;

    localparam int INT_BUS = 8;
    localparam logic [INT_BUS-1:0] INT_NONE = 8'h00;

    // Word index (byte offset >> 2); priorities occupy words 1..NUM_SRC
    localparam logic [5:0] REG_PENDING   = 6'h20;
    localparam logic [5:0] REG_ENABLE    = 6'h21;
    localparam logic [5:0] REG_TRIGGER   = 6'h22;
    localparam logic [5:0] REG_THRESHOLD = 6'h23;
    localparam logic [5:0] REG_CLAIM     = 6'h24;

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PEND      = 2'd1,
        GW_SERV      = 2'd2,
        GW_SERV_PEND = 2'd3
    } gw_state_e;

endpackage

// File: rtl/plic_lite_gateway.sv
// Per-source gateway: 2-flop synchronizer, rising-edge detect and the
// IDLE/PEND/SERV/SERV_PEND claim-complete state machine.
module plic_gateway
    import plic_lite_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pend,
    output logic pend_bit
);

    logic      sync_q1, sync_q2, prev_q;
    logic      rise, trig, new_edge;
    gw_state_e state;

    assign rise     = sync_q2 & ~prev_q;
    assign trig     = edge_mode ? rise : sync_q2;
    // Only edge-mode sources can queue a second request while in service
    assign new_edge = edge_mode & rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
            state   <= GW_IDLE;
        end else begin
            sync_q1 <= irq;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
            case (state)
                GW_IDLE:      if (trig) state <= GW_PEND;
                GW_PEND:      if (claim) state <= new_edge ? GW_SERV_PEND : GW_SERV;
                GW_SERV: begin
                    if (complete)      state <= new_edge ? GW_PEND : GW_IDLE;
                    else if (new_edge) state <= GW_SERV_PEND;
                end
                GW_SERV_PEND: if (complete) state <= GW_PEND;
                default:      state <= GW_IDLE;
            endcase
        end
    end

    assign pend     = (state == GW_PEND);
    assign pend_bit = (state == GW_PEND) || (state == GW_SERV_PEND);

endmodule

// File: rtl/plic_lite.sv
// Platform-level interrupt arbiter: configuration registers, per-source gateways,
// priority arbitration and claim/complete bus decode.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        rdata_o,
    output logic [INT_BUS-1:0] int_flag_o
);

    logic [5:0]         word;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [NUM_SRC:1]   enable, trigger;
    logic [PRIO_W-1:0]  threshold;
    logic [INT_BUS-1:0] best_id, win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic [31:0]        rd_val;
    logic               claim_hit, comp_hit;
    logic [NUM_SRC-1:0] gw_pend, gw_pend_bit, gw_claim, gw_complete;
    logic               unused_bits;

    assign word        = addr_i[7:2];
    assign claim_hit   = re_i && (word == REG_CLAIM) && (best_id != INT_NONE);
    assign comp_hit    = we_i && (word == REG_CLAIM);
    assign unused_bits = ^{addr_i[31:8], addr_i[1:0], data_i};

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign gw_claim[gi]    = claim_hit && (best_id == INT_BUS'(gi + 1));
        assign gw_complete[gi] = comp_hit && (data_i[INT_BUS-1:0] == INT_BUS'(gi + 1));

        plic_gateway u_gateway (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq       (irq_src_i[gi]),
            .edge_mode (trigger[gi+1]),
            .claim     (gw_claim[gi]),
            .complete  (gw_complete[gi]),
            .pend      (gw_pend[gi]),
            .pend_bit  (gw_pend_bit[gi])
        );
    end

    // Strict '>' while scanning upward keeps the lowest ID on a priority tie
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        win_id   = INT_NONE;
        win_prio = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gw_pend[k] && enable[k+1] && (prio[k] != '0) &&
                (prio[k] > threshold) && (prio[k] > win_prio)) begin
                win_id   = INT_BUS'(k + 1);
                win_prio = prio[k];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (word)
            REG_PENDING:   rd_val = 32'({gw_pend_bit, 1'b0});
            REG_ENABLE:    rd_val = 32'({enable, 1'b0});
            REG_TRIGGER:   rd_val = 32'({trigger, 1'b0});
            REG_THRESHOLD: rd_val = 32'(threshold);
            REG_CLAIM:     rd_val = 32'(best_id);
            default: begin
                for (int k = 1; k <= NUM_SRC; k++) begin
                    if (word == 6'(k)) rd_val = 32'(prio[k-1]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the priority array is small configuration state that software expects at 0, so it is reset.
            for (int k = 0; k < NUM_SRC; k++) prio[k] <= '0;
            enable    <= '0;
            trigger   <= '0;
            threshold <= '0;
            best_id   <= INT_NONE;
            rdata_o   <= '0;
        end else begin
            best_id <= win_id;
            if (re_i) rdata_o <= rd_val;
            if (we_i) begin
                case (word)
                    REG_ENABLE:    enable    <= data_i[NUM_SRC:1];
                    REG_TRIGGER:   trigger   <= data_i[NUM_SRC:1];
                    REG_THRESHOLD: threshold <= data_i[PRIO_W-1:0];
                    default: begin
                        for (int k = 1; k <= NUM_SRC; k++) begin
                            if (word == 6'(k)) prio[k-1] <= data_i[PRIO_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

    assign int_flag_o = best_id;

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: latency, arbitration, threshold, edge/level
// gateways, claim/complete corner cases and mid-service reset.
module tb_plic_lite;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src_i;
    logic        we_i, re_i;
    logic [31:0] addr_i, data_i;
    logic [31:0] rdata_o;
    logic [7:0]  int_flag_o;
    logic [31:0] rd;
    int          checks   = 0;
    int          failures = 0;

    plic_lite #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src_i  (irq_src_i),
        .we_i       (we_i),
        .re_i       (re_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rdata_o    (rdata_o),
        .int_flag_o (int_flag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; data_i = d;
        tick(1);
        we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        re_i = 1'b1; addr_i = a;
        tick(1);
        re_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d);
        we_i = 1'b1; re_i = 1'b1; addr_i = a; data_i = wd;
        tick(1);
        we_i = 1'b0; re_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic pulse(input int src);
        irq_src_i[src] = 1'b1;
        tick(1);
        irq_src_i[src] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src_i = '0; we_i = 1'b0; re_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flag", 32'(int_flag_o), 32'h0);
        check("reset_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Level source 3 (ID 4), prio 5: four-edge latency, claim, complete while high
        bus_write(32'h10, 32'd5);
        bus_write(32'h84, 32'h10);
        irq_src_i[3] = 1'b1;
        tick(3);
        check("lvl_flag_before_latency", 32'(int_flag_o), 32'h0);
        tick(1);
        check("lvl_flag_after_4_edges", 32'(int_flag_o), 32'h4);
        bus_read(32'h90, rd);
        check("lvl_claim_id", rd, 32'h4);
        check("lvl_flag_at_claim_edge", 32'(int_flag_o), 32'h4);
        tick(1);
        check("lvl_flag_dropped", 32'(int_flag_o), 32'h0);
        check("rdata_holds", rdata_o, 32'h4);
        bus_write(32'h90, 32'd4);
        check("lvl_complete_edge0", 32'(int_flag_o), 32'h0);
        tick(1);
        check("lvl_complete_edge1", 32'(int_flag_o), 32'h0);
        tick(1);
        check("lvl_complete_edge2", 32'(int_flag_o), 32'h4);
        irq_src_i[3] = 1'b0;
        tick(3);
        bus_read(32'h90, rd);
        bus_write(32'h90, 32'd4);
        tick(2);
        check("lvl_cleanup_flag", 32'(int_flag_o), 32'h0);

        // IDs 2 and 6 tie at prio 3: lowest ID first
        bus_write(32'h08, 32'd3);
        bus_write(32'h18, 32'd3);
        bus_write(32'h84, 32'h54);
        irq_src_i[1] = 1'b1; irq_src_i[5] = 1'b1;
        tick(4);
        check("tie_flag_lowest", 32'(int_flag_o), 32'h2);
        bus_read(32'h90, rd);
        check("tie_claim_id", rd, 32'h2);
        tick(1);
        check("tie_flag_next", 32'(int_flag_o), 32'h6);
        bus_read(32'h18, rd);
        check("prio6_readback", rd, 32'h3);
        irq_src_i[1] = 1'b0; irq_src_i[5] = 1'b0;
        tick(3);
        bus_write(32'h90, 32'd2);
        bus_read(32'h90, rd);
        check("tie_claim_6", rd, 32'h6);
        bus_write(32'h90, 32'd6);
        tick(2);
        check("tie_cleanup_flag", 32'(int_flag_o), 32'h0);

        // ID 5 prio 2 versus threshold 2 then 1
        bus_write(32'h14, 32'd2);
        bus_write(32'h8C, 32'd2);
        bus_write(32'h84, 32'h74);
        irq_src_i[4] = 1'b1;
        tick(4);
        check("thr_blocks", 32'(int_flag_o), 32'h0);
        bus_write(32'h8C, 32'd1);
        check("thr_write_edge", 32'(int_flag_o), 32'h0);
        tick(1);
        check("thr_lowered_flag", 32'(int_flag_o), 32'h5);
        bus_read(32'h80, rd);
        check("thr_pending_reg", rd, 32'h20);
        bus_rw(32'h8C, 32'd0, rd);
        check("rw_returns_old", rd, 32'h1);
        bus_read(32'h8C, rd);
        check("rw_wrote_new", rd, 32'h0);
        irq_src_i[4] = 1'b0;
        tick(3);
        bus_read(32'h90, rd);
        check("thr_claim_5", rd, 32'h5);
        bus_write(32'h90, 32'd5);
        tick(2);

        // Edge-mode ID 1: second edge during service is queued
        bus_write(32'h04, 32'd4);
        bus_write(32'h88, 32'h02);
        bus_write(32'h84, 32'h76);
        bus_read(32'h88, rd);
        check("trigger_readback", rd, 32'h2);
        pulse(0);
        tick(3);
        check("edge_flag", 32'(int_flag_o), 32'h1);
        bus_read(32'h90, rd);
        check("edge_claim_id", rd, 32'h1);
        pulse(0);
        tick(3);
        bus_read(32'h80, rd);
        check("edge_serv_pend_bit", rd, 32'h2);
        check("edge_flag_in_service", 32'(int_flag_o), 32'h0);
        bus_write(32'h90, 32'd1);
        check("edge_complete_edge0", 32'(int_flag_o), 32'h0);
        tick(1);
        check("edge_refires", 32'(int_flag_o), 32'h1);
        bus_read(32'h90, rd);
        bus_write(32'h90, 32'd1);
        bus_write(32'h84, 32'h74);
        pulse(0);
        tick(3);
        check("edge_disabled_flag", 32'(int_flag_o), 32'h0);
        bus_read(32'h80, rd);
        check("edge_disabled_pending", rd, 32'h2);

        // Stray complete, empty claim, unmapped and read-only bits
        bus_write(32'h90, 32'd7);
        bus_read(32'h80, rd);
        check("stray_complete_pending", rd, 32'h2);
        check("stray_complete_flag", 32'(int_flag_o), 32'h0);
        bus_read(32'h90, rd);
        check("empty_claim", rd, 32'h0);
        bus_read(32'h80, rd);
        check("empty_claim_pending", rd, 32'h2);
        bus_read(32'h9C, rd);
        check("unmapped_read", rd, 32'h0);
        bus_write(32'h84, 32'h75);
        bus_read(32'h84, rd);
        check("enable_bit0_ro", rd, 32'h74);

        // Reset while ID 4 is in service
        irq_src_i[3] = 1'b1;
        tick(4);
        check("svc_flag", 32'(int_flag_o), 32'h4);
        bus_read(32'h90, rd);
        check("svc_claim", rd, 32'h4);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("async_reset_flag", 32'(int_flag_o), 32'h0);
        check("async_reset_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;
        tick(1);
        bus_read(32'h84, rd);
        check("post_reset_enable", rd, 32'h0);
        bus_read(32'h10, rd);
        check("post_reset_prio4", rd, 32'h0);
        bus_read(32'h80, rd);
        check("post_reset_pending", rd, 32'h10);
        check("post_reset_flag", 32'(int_flag_o), 32'h0);
        bus_write(32'h10, 32'd5);
        bus_write(32'h84, 32'h10);
        check("reenable_edge0", 32'(int_flag_o), 32'h0);
        tick(1);
        check("reenable_fires", 32'(int_flag_o), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
